gb_host_bridge: RTL

//  Host-side initiator for the ghostbus: converts a byte-stream command channel (UART/USB FIFO side)

---
 rtl/gb_host_pkg.sv | 19 +
 rtl/gb_byte_ser.sv | 39 +++
 rtl/gb_host_bridge.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/gb_host_pkg.sv
// Shared constants and FSM state encoding for the ghostbus host bridge.
package gb_host_pkg;

  localparam logic [7:0] CMD_WR  = 8'h00;
  localparam logic [7:0] CMD_RD  = 8'h80;
  localparam logic [7:0] RSP_ACK = 8'h00;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4,
    S_WAIT  = 3'd5,
    S_RESP  = 3'd6
  } gb_state_e;

endpackage

// File: rtl/gb_byte_ser.sv
// Response serializer: loads a DW-wide word plus a byte count and emits the
// bytes MSB-first on a valid/ready handshake.
module gb_byte_ser #(
  parameter int DW = 32,
  parameter int CW = $clog2(DW / 8 + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_word,
  input  logic [CW-1:0] i_nbytes,
  input  logic          i_ready,
  output logic [7:0]    o_data,
  output logic          o_valid,
  output logic          o_last
);

  logic [DW-1:0] r_word;
  logic [CW-1:0] r_cnt;

  // Word/count registers: load, or shift out one byte per accepted handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_word <= i_word;
      r_cnt  <= i_nbytes;
    end else if (o_valid && i_ready) begin
      r_word <= r_word << 4'd8;
      r_cnt  <= r_cnt - CW'(1);
    end
  end

  assign o_valid = (r_cnt != '0);
  assign o_data  = r_word[DW-1 -: 8];
  assign o_last  = o_valid & i_ready & (r_cnt == CW'(1));

endmodule

// File: rtl/gb_host_bridge.sv
// Host-side ghostbus initiator: byte-stream command packets in, single
// write/read bus transactions out, byte-stream responses back.
module gb_host_bridge
  import gb_host_pkg::*;
#(
  parameter int AW      = 24,
  parameter int DW      = 32,
  parameter int RD      = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          gb_clk,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_wdata,
  output logic          gb_wen,
  output logic          gb_rstb,
  input  logic [DW-1:0] gb_rdata
);

  localparam int NA   = AW / 8;
  localparam int ND   = DW / 8;
  localparam int NMAX = (NA > ND) ? NA : ND;
  localparam int BCW  = $clog2(NMAX + 1);
  localparam int SCW  = $clog2(ND + 1);
  localparam int RCW  = $clog2(RD + 1);
  localparam int TCW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TCW-1:0] TO_LAST = (TIMEOUT > 0) ? TCW'(TIMEOUT - 1) : '0;
  localparam logic [DW-1:0]  W_ERR   = {RSP_ERR, {(DW - 8){1'b0}}};
  localparam logic [DW-1:0]  W_ACK   = {RSP_ACK, {(DW - 8){1'b0}}};

  gb_state_e       r_state, w_state_nxt;
  logic            r_rx_ready, r_wen, r_rstb, r_is_wr;
  logic [BCW-1:0]  r_byte_cnt;
  logic [TCW-1:0]  r_to_cnt;
  logic [RCW-1:0]  r_rd_cnt;
  logic [AW-1:0]   r_addr_sh, r_gb_addr, w_addr_full;
  logic [DW-1:0]   r_data_sh, r_gb_wdata, w_data_full;
  logic            w_rx_acc, w_to_hit, w_addr_last, w_data_last;
  logic            w_ser_load, w_ser_last;
  logic [DW-1:0]   w_ser_word;
  logic [SCW-1:0]  w_ser_n;

  assign w_rx_acc    = rx_valid & r_rx_ready;
  assign w_addr_full = (r_addr_sh << 4'd8) | AW'(rx_data);
  assign w_data_full = (r_data_sh << 4'd8) | DW'(rx_data);
  assign w_addr_last = (r_byte_cnt == BCW'(NA - 1));
  assign w_data_last = (r_byte_cnt == BCW'(ND - 1));
  assign w_to_hit    = (TIMEOUT > 0) && !w_rx_acc && (r_to_cnt == TO_LAST);

  // Next-state and serializer-load decode.
  always_comb begin
    w_state_nxt = r_state;
    w_ser_load  = 1'b0;
    w_ser_word  = '0;
    w_ser_n     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_rx_acc) begin
          if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
            w_state_nxt = S_ADDR;
          end else begin
            w_state_nxt = S_RESP;
            w_ser_load  = 1'b1;
            w_ser_word  = W_ERR;
            w_ser_n     = SCW'(1);
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ADDR: begin
        if (w_rx_acc) begin
          if (w_addr_last) begin
            w_state_nxt = r_is_wr ? S_DATA : S_READ;
          end else begin
            w_state_nxt = S_ADDR;
          end
        end else if (w_to_hit) begin
          w_state_nxt = S_RESP;
          w_ser_load  = 1'b1;
          w_ser_word  = W_ERR;
          w_ser_n     = SCW'(1);
        end else begin
          w_state_nxt = S_ADDR;
        end
      end
      S_DATA: begin
        if (w_rx_acc) begin
          w_state_nxt = w_data_last ? S_WRITE : S_DATA;
        end else if (w_to_hit) begin
          w_state_nxt = S_RESP;
          w_ser_load  = 1'b1;
          w_ser_word  = W_ERR;
          w_ser_n     = SCW'(1);
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_WRITE: begin
        w_state_nxt = S_RESP;
        w_ser_load  = 1'b1;
        w_ser_word  = W_ACK;
        w_ser_n     = SCW'(1);
      end
      S_READ: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // r_rd_cnt tracks how many cycles have elapsed since the rstb cycle.
        if (r_rd_cnt == RCW'(RD)) begin
          w_state_nxt = S_RESP;
          w_ser_load  = 1'b1;
          w_ser_word  = gb_rdata;
          w_ser_n     = SCW'(ND);
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP: begin
        if (w_ser_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register, packet shift-in, counters and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rx_ready <= 1'b0;
      r_wen      <= 1'b0;
      r_rstb     <= 1'b0;
      r_is_wr    <= 1'b0;
      r_byte_cnt <= '0;
      r_to_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_addr_sh  <= '0;
      r_data_sh  <= '0;
      r_gb_addr  <= '0;
      r_gb_wdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rx_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_ADDR) ||
                    (w_state_nxt == S_DATA);
      r_wen      <= (w_state_nxt == S_WRITE);
      r_rstb     <= (w_state_nxt == S_READ);

      if (w_rx_acc && (r_state == S_IDLE)) begin
        r_is_wr    <= (rx_data == CMD_WR);
        r_byte_cnt <= '0;
      end else if (w_rx_acc && (r_state == S_ADDR)) begin
        r_addr_sh  <= w_addr_full;
        r_byte_cnt <= w_addr_last ? '0 : r_byte_cnt + BCW'(1);
      end else if (w_rx_acc && (r_state == S_DATA)) begin
        r_data_sh  <= w_data_full;
        r_byte_cnt <= w_data_last ? '0 : r_byte_cnt + BCW'(1);
      end

      // Bus address/data only move when a strobe is launched.
      if ((r_state == S_ADDR) && (w_state_nxt == S_READ)) begin
        r_gb_addr <= w_addr_full;
      end else if ((r_state == S_DATA) && (w_state_nxt == S_WRITE)) begin
        r_gb_addr  <= r_addr_sh;
        r_gb_wdata <= w_data_full;
      end

      if ((TIMEOUT > 0) && !w_rx_acc &&
          ((r_state == S_ADDR) || (r_state == S_DATA))) begin
        r_to_cnt <= r_to_cnt + TCW'(1);
      end else begin
        r_to_cnt <= '0;
      end

      if (r_state == S_READ) begin
        r_rd_cnt <= RCW'(1);
      end else if ((r_state == S_WAIT) && (r_rd_cnt != RCW'(RD))) begin
        r_rd_cnt <= r_rd_cnt + RCW'(1);
      end else begin
        r_rd_cnt <= '0;
      end
    end
  end

  gb_byte_ser #(.DW(DW), .CW(SCW)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_ser_load),
    .i_word   (w_ser_word),
    .i_nbytes (w_ser_n),
    .i_ready  (tx_ready),
    .o_data   (tx_data),
    .o_valid  (tx_valid),
    .o_last   (w_ser_last)
  );

  assign rx_ready = r_rx_ready;
  assign gb_clk   = clk;
  assign gb_addr  = r_gb_addr;
  assign gb_wdata = r_gb_wdata;
  assign gb_wen   = r_wen;
  assign gb_rstb  = r_rstb;

endmodule
